// File: rtl/ysyx_24090012_ifu.sv
// rtl/ysyx_24090012_ifu.sv - instruction fetch unit: single-outstanding SRAM read master feeding decode
// Optional perf counters: define YSYX_24090012_IFU_PERF_EN to add o_fetch_cnt / o_stall_cnt.
module ysyx_24090012_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    // SRAM read/write master
    output logic [31:0] o_addr,
    output logic        o_arvalid,
    input  logic        i_arready,
    input  logic [31:0] i_rdata,
    input  logic        i_rvalid,
    output logic        o_rready,
    output logic        o_wen,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wmask,
    // decode stage
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    // writeback redirect
    input  logic [31:0] i_next_pc,
    input  logic        i_pc_update
`ifdef YSYX_24090012_IFU_PERF_EN
    ,
    output logic [31:0] o_fetch_cnt,
    output logic [31:0] o_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_HOLD    = 2'd2,
        S_WAIT_PC = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic        r_arvalid;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_inst_valid;

    logic        w_rd_hs;
    logic        w_dec_hs;
    logic        w_redirect;
    logic        w_unused;

    // Read data is only taken in FETCH, where rready is high; elsewhere rvalid is dropped.
    assign w_rd_hs    = (r_state == S_FETCH) && i_rvalid;
    assign w_dec_hs   = (r_state == S_HOLD) && r_inst_valid && i_inst_ready;
    assign w_redirect = (r_state == S_WAIT_PC) && i_pc_update;

    // arready is advisory only and the low next_pc bits are discarded by design.
    assign w_unused = ^{i_arready, i_next_pc[1:0]};

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    w_next_state = S_FETCH;
            S_FETCH:   if (w_rd_hs)    w_next_state = S_HOLD;
            S_HOLD:    if (w_dec_hs)   w_next_state = S_WAIT_PC;
            S_WAIT_PC: if (w_redirect) w_next_state = S_FETCH;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // State-decoded and fixed outputs.
    always_comb begin
        o_rready     = (r_state == S_FETCH);
        o_addr       = {r_pc[31:2], 2'b00};
        o_arvalid    = r_arvalid;
        o_inst       = r_inst;
        o_inst_pc    = r_inst_pc;
        o_inst_valid = r_inst_valid;
        o_wen        = 1'b0;
        o_wdata      = 32'h0;
        o_wmask      = 4'h0;
    end

    // Fetch datapath: pc, request valid and the buffered instruction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc         <= {RESET_PC[31:2], 2'b00};
            r_arvalid    <= 1'b0;
            r_inst       <= 32'h0;
            r_inst_pc    <= 32'h0;
            r_inst_valid <= 1'b0;
        end else begin
            // arvalid tracks entry into FETCH so it is registered, never combinational.
            r_arvalid <= (w_next_state == S_FETCH);
            if (w_rd_hs) begin
                r_inst       <= i_rdata;
                r_inst_pc    <= {r_pc[31:2], 2'b00};
                r_inst_valid <= 1'b1;
            end else if (w_dec_hs) begin
                r_inst_valid <= 1'b0;
            end
            if (w_redirect) begin
                r_pc <= {i_next_pc[31:2], 2'b00};
            end
        end
    end

`ifdef YSYX_24090012_IFU_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    // Completed fetches and FETCH cycles spent waiting on the slave; both wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_cnt <= 32'h0;
            r_stall_cnt <= 32'h0;
        end else if (r_state == S_FETCH) begin
            if (i_rvalid) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end else begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign o_fetch_cnt = r_fetch_cnt;
    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ysyx_24090012_ifu.sv
// tb/tb_ysyx_24090012_ifu.sv - directed scoreboard bench for ysyx_24090012_ifu
module tb_ysyx_24090012_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] next_pc;
    logic        pc_update;
`ifdef YSYX_24090012_IFU_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    ysyx_24090012_ifu #(.RESET_PC(32'h8000_0000)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_addr       (addr),
        .o_arvalid    (arvalid),
        .i_arready    (arready),
        .i_rdata      (rdata),
        .i_rvalid     (rvalid),
        .o_rready     (rready),
        .o_wen        (wen),
        .o_wdata      (wdata),
        .o_wmask      (wmask),
        .o_inst       (inst),
        .o_inst_pc    (inst_pc),
        .o_inst_valid (inst_valid),
        .i_inst_ready (inst_ready),
        .i_next_pc    (next_pc),
        .i_pc_update  (pc_update)
`ifdef YSYX_24090012_IFU_PERF_EN
        ,
        .o_fetch_cnt  (fetch_cnt),
        .o_stall_cnt  (stall_cnt)
`endif
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Serve one read: `waits` FETCH cycles without rvalid, then return `data`.
    task automatic fetch(input logic [31:0] exp_pc, input logic [31:0] data, input int waits, input bit upd);
        for (int i = 0; i < waits; i++) begin
            chk("fetch_arvalid", {31'b0, arvalid}, 32'd1);
            chk("fetch_rready", {31'b0, rready}, 32'd1);
            chk("fetch_addr", addr, exp_pc);
            chk("fetch_no_inst_valid", {31'b0, inst_valid}, 32'd0);
            if (upd && i == 0) begin
                pc_update = 1'b1;
                next_pc   = 32'h9000_0000;
            end
            step();
            pc_update = 1'b0;
        end
        rvalid = 1'b1;
        rdata  = data;
        sb_q.push_back({data, exp_pc});
        step();
        rvalid = 1'b0;
        rdata  = 32'hdead_beef;
        chk("resp_inst_valid", {31'b0, inst_valid}, 32'd1);
        chk("resp_inst", inst, data);
        chk("resp_inst_pc", inst_pc, exp_pc);
        chk("resp_arvalid_low", {31'b0, arvalid}, 32'd0);
        chk("resp_rready_low", {31'b0, rready}, 32'd0);
    endtask

    // Decode accepts the held instruction; compare against the scoreboard head.
    task automatic accept();
        logic [63:0] e;
        inst_ready = 1'b1;
        n_vec++;
        assert (sb_q.size() > 0) else begin
            n_err++;
            $error("FAIL sb_empty observed=%0d expected=%0d", 0, 1);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_inst", inst, e[63:32]);
            chk("sb_inst_pc", inst_pc, e[31:0]);
        end
        step();
        inst_ready = 1'b0;
        chk("accept_inst_valid_low", {31'b0, inst_valid}, 32'd0);
        chk("accept_arvalid_low", {31'b0, arvalid}, 32'd0);
    endtask

    task automatic redirect(input logic [31:0] npc, input logic [31:0] exp_addr);
        pc_update = 1'b1;
        next_pc   = npc;
        step();
        pc_update = 1'b0;
        chk("redir_arvalid", {31'b0, arvalid}, 32'd1);
        chk("redir_addr", addr, exp_addr);
    endtask

    initial begin
        rst = 1'b1; arready = 1'b1; rdata = 32'h0; rvalid = 1'b0;
        inst_ready = 1'b0; next_pc = 32'h0; pc_update = 1'b0;
        step(); step();

        // reset state
        chk("rst_arvalid", {31'b0, arvalid}, 32'd0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_rready", {31'b0, rready}, 32'd0);
        chk("rst_addr", addr, 32'h8000_0000);
        chk("tie_wr", {wdata[30:0] | {27'b0, wmask}, wen}, 32'd0);

        rst = 1'b0;
        step();

        // first fetch at reset vector, two wait cycles
        fetch(32'h8000_0000, 32'h0000_0413, 2, 1'b0);

        // decode stalls 5 cycles; a redirect during HOLD must be ignored
        for (int i = 0; i < 5; i++) begin
            chk("hold_inst_valid", {31'b0, inst_valid}, 32'd1);
            chk("hold_inst", inst, 32'h0000_0413);
            chk("hold_inst_pc", inst_pc, 32'h8000_0000);
            chk("hold_arvalid", {31'b0, arvalid}, 32'd0);
            if (i == 2) begin
                pc_update = 1'b1;
                next_pc   = 32'h8000_1000;
            end
            step();
            pc_update = 1'b0;
        end
        accept();

        // WAIT_PC: stray rvalid ignored, no request issued
        rvalid = 1'b1; rdata = 32'h1234_5678;
        step();
        rvalid = 1'b0;
        chk("waitpc_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("waitpc_inst", inst, 32'h0000_0413);
        chk("waitpc_arvalid", {31'b0, arvalid}, 32'd0);

        // misaligned redirect: low bits dropped
        redirect(32'h8000_0007, 32'h8000_0004);
        fetch(32'h8000_0004, 32'h0010_0093, 2, 1'b0);
        accept();

        // redirect after the ignored HOLD update; pc_update during FETCH ignored
        redirect(32'h8000_0008, 32'h8000_0008);
        fetch(32'h8000_0008, 32'h0020_0113, 2, 1'b1);
`ifdef YSYX_24090012_IFU_PERF_EN
        chk("perf_fetch_cnt", fetch_cnt, 32'd3);
        chk("perf_stall_cnt", stall_cnt, 32'd6);
`endif
        accept();

        // reset mid-FETCH with a late response
        redirect(32'h8000_0010, 32'h8000_0010);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        rvalid = 1'b1; rdata = 32'hbad0_bad0;
        chk("midrst_arvalid", {31'b0, arvalid}, 32'd0);
        chk("midrst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("midrst_inst", inst, 32'h0);
        chk("midrst_rready", {31'b0, rready}, 32'd0);
`ifdef YSYX_24090012_IFU_PERF_EN
        chk("midrst_fetch_cnt", fetch_cnt, 32'd0);
        chk("midrst_stall_cnt", stall_cnt, 32'd0);
`endif
        step();
        rvalid = 1'b0;
        chk("restart_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("restart_inst", inst, 32'h0);
        fetch(32'h8000_0000, 32'h0000_0513, 1, 1'b0);
        accept();

        chk("sb_drained", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_24090012_ifu.md
YSYX_24090012_IFU -- requirements
Module: ysyx_24090012_ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000: first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 addr  output  32  fetch address to SRAM slave.
REQ-005 arvalid  output  1  read request valid (master -> slave).
REQ-006 arready  input  1  slave address ready; informational only, never gates state.
REQ-007 rdata  input  32  instruction word from slave.
REQ-008 rvalid  input  1  slave data valid.
REQ-009 rready  output  1  master can accept data.
REQ-010 wen / wdata / wmask  output  1/32/4  tied to 0 / 32'h0 / 4'h0.
REQ-011 inst  output  32  buffered instruction to decode stage.
REQ-012 inst_pc  output  32  address of inst.
REQ-013 inst_valid  output  1  inst/inst_pc valid.
REQ-014 inst_ready  input  1  decode stage accepts inst.
REQ-015 next_pc  input  32  next fetch address from writeback.
REQ-016 pc_update  input  1  next_pc valid, one-cycle pulse.

Function
REQ-017 States: IDLE, FETCH, HOLD, WAIT_PC; 2-bit registered state.
REQ-018 IDLE -> FETCH unconditionally on next edge; arvalid=1 registered on the same edge.
REQ-019 FETCH: arvalid=1, rready=1, addr=pc held stable until rvalid&&rready.
REQ-020 On rvalid&&rready in FETCH: inst<=rdata, inst_pc<=pc, inst_valid<=1, arvalid<=0, state -> HOLD.
REQ-021 HOLD: inst, inst_pc stable, inst_valid=1 until inst_valid&&inst_ready; then inst_valid<=0, state -> WAIT_PC.
REQ-022 WAIT_PC: on pc_update, pc<={next_pc[31:2],2'b00}, arvalid<=1, state -> FETCH; low 2 bits of next_pc discarded.
REQ-023 pc_update in IDLE, FETCH, HOLD ignored; pc unchanged.
REQ-024 rvalid outside FETCH ignored; rready=0 outside FETCH.
REQ-025 inst_valid to decode: exactly 1 cycle after rvalid&&rready edge; at most one outstanding request ever.
REQ-026 Latency from pc_update to arvalid high: 1 cycle; total fetch latency set by slave.
REQ-027 inst_ready in same cycle as inst_valid rising: handshake completes on that edge, inst_valid held 1 cycle minimum.
REQ-028 No address-range or alignment fault reporting; addr[1:0] always 2'b00.

Reset
REQ-029 On rst: state=IDLE, pc=RESET_PC, arvalid=0, inst_valid=0, inst=32'h0, inst_pc=32'h0.
REQ-030 rst during FETCH abandons request: arvalid=0 next edge; late rvalid after reset ignored (REQ-024); fetch restarts at RESET_PC.

Configuration
REQ-031 Macro YSYX_24090012_IFU_PERF_EN defined: adds outputs fetch_cnt[31:0] (increments per rvalid&&rready) and stall_cnt[31:0] (increments each FETCH cycle without rvalid); both reset to 0, wrap at 2^32.
REQ-032 Macro undefined: counters and ports absent; all other behaviour identical.

Verification
REQ-033 Reset release, slave returns 32'h0000_0413 after 2 cycles -> addr=32'h8000_0000, arvalid high until handshake, inst=32'h0000_0413, inst_pc=32'h8000_0000, inst_valid next cycle.
REQ-034 inst_ready held low 5 cycles -> inst/inst_pc/inst_valid stable 5 cycles; no new arvalid.
REQ-035 WAIT_PC, pc_update with next_pc=32'h8000_0007 -> next cycle arvalid=1, addr=32'h8000_0004.
REQ-036 pc_update pulsed in HOLD with 32'h8000_1000 -> ignored; after later pc_update 32'h8000_0008, addr=32'h8000_0008.
REQ-037 rst asserted mid-FETCH, rvalid arrives one cycle later -> data dropped, inst_valid=0, fetch restarts at 32'h8000_0000.
REQ-038 PERF_EN build, 3 fetches each with 2 wait cycles -> fetch_cnt=3, stall_cnt=6.
